// File: rtl/fc_w_buf_sched.sv
// fc_w_buf_sched: write/read scheduler for the FC weight buffer.
// Accepts one FC_SIZE-byte row per handshake and writes it into the lane RAMs,
// then replays the stored layer to the FC array as stallable read passes.
// Optional macro FC_W_SKEW_EN: lane k is offset by k rows, and each read pass
// runs N+FC_SIZE-1 addresses, so the systolic array is fed diagonally.
module fc_w_buf_sched #(
  parameter int FC_SIZE = 10,
  parameter int DEPTH   = 120
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cfg_start_i,
  input  logic [6:0]              cfg_rows_i,
  output logic                    cfg_err_o,
  input  logic                    s_valid_i,
  output logic                    s_ready_o,
  input  logic [FC_SIZE-1:0][7:0] s_data_i,
  output logic                    buf_wren_o,
  output logic [FC_SIZE-1:0][6:0] buf_wrptr_o,
  output logic [FC_SIZE-1:0][7:0] buf_wdata_o,
  output logic                    buf_rden_o,
  output logic [6:0]              buf_rdptr_o,
  input  logic                    rd_start_i,
  input  logic                    rd_stall_i,
  output logic                    w_valid_o,
  output logic                    w_last_o,
  output logic [FC_SIZE-1:0]      w_lane_vld_o,
  output logic                    loaded_o,
  output logic                    busy_o
);
  typedef enum logic [1:0] {IDLE, LOAD, READY, READ} state_e;

  localparam logic [7:0] DEPTH8 = 8'(DEPTH);
`ifdef FC_W_SKEW_EN
  localparam logic [7:0] SKEW = 8'(FC_SIZE - 1);
`else
  localparam logic [7:0] SKEW = 8'd0;
`endif

  state_e     state_q, state_d;
  logic [6:0] n_q, n_d, wr_row_q, wr_row_d, rd_row_q, rd_row_d;
  logic       loaded_q, loaded_d;
  logic       cfg_err_q, wren_q, w_valid_q, w_last_q;
  logic [FC_SIZE-1:0][6:0] wrptr_q, wrptr_d;
  logic [FC_SIZE-1:0][7:0] wdata_q;
  logic [FC_SIZE-1:0]      lane_vld_q, lane_vld;
  logic [7:0] cfg_len, pass_len;
  logic       cfg_ok, accept, issue, last_wr, last_rd;

  // Length checks are done in 8 bits: N+FC_SIZE-1 can exceed 127.
  assign cfg_len  = {1'b0, cfg_rows_i} + SKEW;
  assign cfg_ok   = (cfg_rows_i != 7'd0) && (cfg_len <= DEPTH8);
  assign pass_len = {1'b0, n_q} + SKEW;

  assign s_ready_o = (state_q == LOAD);
  assign accept    = s_valid_i && s_ready_o;
  assign issue     = (state_q == READ) && !rd_stall_i;
  assign last_wr   = (wr_row_q == n_q - 7'd1);
  assign last_rd   = ({1'b0, rd_row_q} == pass_len - 8'd1);

  // Per-lane write address and read-data qualifier.
  for (genvar k = 0; k < FC_SIZE; k++) begin : g_lane
`ifdef FC_W_SKEW_EN
    assign wrptr_d[k]  = wr_row_q + 7'(k);
    assign lane_vld[k] = ({1'b0, rd_row_q} >= 8'(k)) &&
                         (({1'b0, rd_row_q} - 8'(k)) < {1'b0, n_q});
`else
    assign wrptr_d[k]  = wr_row_q;
    assign lane_vld[k] = 1'b1;
`endif
  end

  // Next state; a valid config start overrides everything, including a
  // read start in the same cycle.
  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    wr_row_d = wr_row_q;
    rd_row_d = rd_row_q;
    loaded_d = loaded_q;
    case (state_q)
      LOAD: if (accept) begin
        wr_row_d = wr_row_q + 7'd1;
        if (last_wr) begin
          state_d  = READY;
          loaded_d = 1'b1;
        end
      end
      READY: if (rd_start_i && !cfg_start_i) begin
        state_d  = READ;
        rd_row_d = 7'd0;
      end
      READ: if (issue) begin
        rd_row_d = rd_row_q + 7'd1;
        if (last_rd) state_d = READY;
      end
      default: ;
    endcase
    if (cfg_start_i && cfg_ok) begin
      state_d  = LOAD;
      n_d      = cfg_rows_i;
      wr_row_d = 7'd0;
      rd_row_d = 7'd0;
      loaded_d = 1'b0;
    end
  end

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      n_q      <= '0;
      wr_row_q <= '0;
      rd_row_q <= '0;
      loaded_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      wr_row_q <= wr_row_d;
      rd_row_q <= rd_row_d;
      loaded_q <= loaded_d;
    end
  end

  // Registered write strobe/address/data and 1-cycle-delayed read qualifiers
  // that line up with the RAM read latency.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cfg_err_q  <= 1'b0;
      wren_q     <= 1'b0;
      wrptr_q    <= '0;
      wdata_q    <= '0;
      w_valid_q  <= 1'b0;
      w_last_q   <= 1'b0;
      lane_vld_q <= '0;
    end else begin
      cfg_err_q <= cfg_start_i && !cfg_ok;
      wren_q    <= accept;
      if (accept) begin
        wrptr_q <= wrptr_d;
        wdata_q <= s_data_i;
      end
      w_valid_q  <= issue;
      w_last_q   <= issue && last_rd;
      lane_vld_q <= issue ? lane_vld : '0;
    end
  end

  assign cfg_err_o    = cfg_err_q;
  assign buf_wren_o   = wren_q;
  assign buf_wrptr_o  = wrptr_q;
  assign buf_wdata_o  = wdata_q;
  assign buf_rden_o   = issue;
  assign buf_rdptr_o  = rd_row_q;
  assign w_valid_o    = w_valid_q;
  assign w_last_o     = w_last_q;
  assign w_lane_vld_o = lane_vld_q;
  assign loaded_o     = loaded_q;
  assign busy_o       = (state_q == LOAD) || (state_q == READ);
endmodule

// File: tb/tb_fc_w_buf_sched.sv
// Bench for fc_w_buf_sched: a RAM model fed by the DUT write port, a per-row
// expectation of write address/data, and a per-issue expectation of read
// qualifiers/data derived from the layer rows the bench sent.
module tb_fc_w_buf_sched;
  localparam int FC    = 10;
  localparam int DEPTH = 120;
`ifdef FC_W_SKEW_EN
  localparam int SK = FC - 1;
`else
  localparam int SK = 0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic cfg_start_i, cfg_err_o, s_valid_i, s_ready_o;
  logic [6:0] cfg_rows_i;
  logic [FC-1:0][7:0] s_data_i, buf_wdata_o;
  logic [FC-1:0][6:0] buf_wrptr_o;
  logic buf_wren_o, buf_rden_o, rd_start_i, rd_stall_i;
  logic [6:0] buf_rdptr_o;
  logic w_valid_o, w_last_o, loaded_o, busy_o;
  logic [FC-1:0] w_lane_vld_o;

  fc_w_buf_sched #(.FC_SIZE(FC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_start_i(cfg_start_i), .cfg_rows_i(cfg_rows_i), .cfg_err_o(cfg_err_o),
    .s_valid_i(s_valid_i), .s_ready_o(s_ready_o), .s_data_i(s_data_i),
    .buf_wren_o(buf_wren_o), .buf_wrptr_o(buf_wrptr_o), .buf_wdata_o(buf_wdata_o),
    .buf_rden_o(buf_rden_o), .buf_rdptr_o(buf_rdptr_o),
    .rd_start_i(rd_start_i), .rd_stall_i(rd_stall_i),
    .w_valid_o(w_valid_o), .w_last_o(w_last_o), .w_lane_vld_o(w_lane_vld_o),
    .loaded_o(loaded_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // model state
  logic [7:0] ram [FC][128];
  logic [7:0] layer_data [128][FC];
  int layer_n = 0;
  int iss_q[$];
  int nvalid = 0, nlast = 0;
  bit acc_now = 0, prev_acc = 0, prev_rden = 0;
  logic [FC-1:0][6:0] acc_ptr = '0, prev_ptr = '0;
  logic [FC-1:0][7:0] acc_dat = '0, prev_dat = '0;
  logic pl_last = 1'b0;
  logic [FC-1:0] pl_vld = '0;
  logic [FC-1:0][7:0] pl_obs = '0, pl_exp = '0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called mid-cycle once inputs are settled: checks what the DUT presents
  // this cycle and updates the RAM/expectation model.
  task automatic observe();
    logic [FC-1:0][7:0] od, ed;
    logic [FC-1:0] v;
    int a;
    chk("wren", 128'(buf_wren_o), 128'(prev_acc));
    if (buf_wren_o) begin
      if (prev_acc) begin
        chk("wrptr", 128'(buf_wrptr_o), 128'(prev_ptr));
        chk("wdata", 128'(buf_wdata_o), 128'(prev_dat));
      end
      for (int k = 0; k < FC; k++) ram[k][buf_wrptr_o[k]] = buf_wdata_o[k];
    end
    prev_acc = acc_now; prev_ptr = acc_ptr; prev_dat = acc_dat;
    chk("w_valid", 128'(w_valid_o), 128'(prev_rden));
    if (w_valid_o && prev_rden) begin
      chk("w_last", 128'(w_last_o), 128'(pl_last));
      chk("w_lane_vld", 128'(w_lane_vld_o), 128'(pl_vld));
      chk("rdata", 128'(pl_obs), 128'(pl_exp));
      nvalid++;
      if (w_last_o) nlast++;
    end
    prev_rden = buf_rden_o;
    if (buf_rden_o) begin
      a = int'(buf_rdptr_o);
      iss_q.push_back(a);
      pl_last = (a == layer_n + SK - 1);
      od = '0; ed = '0; v = '0;
      for (int k = 0; k < FC; k++) begin
        if (SK == 0 || (a >= k && a <= k + layer_n - 1)) begin
          v[k]  = 1'b1;
          od[k] = ram[k][a];
          ed[k] = layer_data[a - ((SK == 0) ? 0 : k)][k];
        end
      end
      pl_vld = v; pl_obs = od; pl_exp = ed;
    end
  endtask

  // Inputs are driven at posedge+1; observe at posedge+2; return at next posedge+1.
  task automatic cycle();
    #1;
    observe();
    @(posedge clk);
    #1;
  endtask

  task automatic bad_cfg(input int n, input bit exp_loaded);
    cfg_start_i = 1'b1; cfg_rows_i = 7'(n);
    cycle();
    cfg_start_i = 1'b0;
    chk("cfg_err_pulse", 128'(cfg_err_o), 128'(1));
    chk("cfg_err_busy", 128'(busy_o), 128'(0));
    chk("cfg_err_loaded", 128'(loaded_o), 128'(exp_loaded));
    cycle();
    chk("cfg_err_once", 128'(cfg_err_o), 128'(0));
  endtask

  task automatic start_cfg(input int n);
    cfg_start_i = 1'b1; cfg_rows_i = 7'(n);
    cycle();
    cfg_start_i = 1'b0;
    layer_n = n;
    chk("load_s_ready", 128'(s_ready_o), 128'(1));
    chk("load_loaded", 128'(loaded_o), 128'(0));
    chk("load_busy", 128'(busy_o), 128'(1));
  endtask

  task automatic send_rows(input int n, input bit fixed);
    logic [FC-1:0][7:0] d;
    logic [FC-1:0][6:0] p;
    for (int r = 0; r < n; r++) begin
      if (!fixed && $urandom_range(0, 3) == 0) begin
        s_valid_i = 1'b0; acc_now = 0;
        cycle();
      end
      for (int k = 0; k < FC; k++) begin
        d[k] = fixed ? 8'(8'h10 + r) : 8'($urandom);
        p[k] = 7'(r + ((SK == 0) ? 0 : k));
        layer_data[r][k] = d[k];
      end
      s_data_i = d; s_valid_i = 1'b1;
      rd_start_i = fixed ? 1'b0 : 1'($urandom_range(0, 1));
      chk("s_ready", 128'(s_ready_o), 128'(1));
      acc_now = 1; acc_ptr = p; acc_dat = d;
      cycle();
      chk("loaded_after_beat", 128'(loaded_o), 128'(r == n - 1));
    end
    s_valid_i = 1'b0; acc_now = 0; rd_start_i = 1'b0;
    cycle();
    chk("ready_not_busy", 128'(busy_o), 128'(0));
  endtask

  // mode 0: no stall, 1: two stall cycles before row 2, 2: random stall
  task automatic read_pass(input int mode);
    int p, base, cyc, st;
    bit stall;
    p = layer_n + SK;
    nvalid = 0; nlast = 0;
    base = iss_q.size();
    rd_start_i = 1'b1;
    cycle();
    rd_start_i = 1'b0;
    chk("issue_after_start", 128'(iss_q.size() - base), 128'(0));
    cyc = 0; st = 0;
    while (iss_q.size() - base < p && cyc < 2000) begin
      case (mode)
        1:       stall = (iss_q.size() - base == 2) && (st < 2);
        2:       stall = ($urandom_range(0, 2) == 0);
        default: stall = 1'b0;
      endcase
      if (stall) st++;
      if (mode == 2) rd_start_i = 1'($urandom_range(0, 7) == 0);
      rd_stall_i = stall;
      cycle();
      cyc++;
    end
    rd_stall_i = 1'b0; rd_start_i = 1'b0;
    chk("pass_timeout", 128'(cyc < 2000), 128'(1));
    cycle();
    chk("pass_len", 128'(iss_q.size() - base), 128'(p));
    for (int i = 0; i < p; i++)
      if (base + i < iss_q.size()) chk("rdptr_seq", 128'(iss_q[base + i]), 128'(i));
    chk("pass_nvalid", 128'(nvalid), 128'(p));
    chk("pass_nlast", 128'(nlast), 128'(1));
    chk("pass_ready_busy", 128'(busy_o), 128'(0));
    chk("pass_loaded", 128'(loaded_o), 128'(1));
    if (mode == 0) chk("pass_cycles", 128'(cyc), 128'(p));
    if (mode == 1) chk("pass_cycles_stall", 128'(cyc), 128'(p + 2));
  endtask

  initial begin
    int base, guard;
    rst_n = 1'b0; cfg_start_i = 1'b0; cfg_rows_i = '0; s_valid_i = 1'b0;
    s_data_i = '0; rd_start_i = 1'b0; rd_stall_i = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_wren", 128'(buf_wren_o), 128'(0));
    chk("rst_wrptr", 128'(buf_wrptr_o), 128'(0));
    chk("rst_wdata", 128'(buf_wdata_o), 128'(0));
    chk("rst_rd", 128'({buf_rden_o, buf_rdptr_o}), 128'(0));
    chk("rst_w", 128'({w_valid_o, w_last_o, w_lane_vld_o}), 128'(0));
    chk("rst_status", 128'({loaded_o, busy_o, s_ready_o, cfg_err_o}), 128'(0));
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // read start in IDLE is ignored
    rd_start_i = 1'b1;
    cycle();
    rd_start_i = 1'b0;
    cycle();
    chk("idle_rdstart", 128'(iss_q.size()), 128'(0));
    chk("idle_busy", 128'(busy_o), 128'(0));

    // rejected configs, boundaries of the row count
    bad_cfg(0, 1'b0);
    bad_cfg(DEPTH - SK + 1, 1'b0);

    // fixed pattern load, two identical passes
    start_cfg(4);
    send_rows(4, 1'b1);
    read_pass(0);
    read_pass(0);
    bad_cfg(0, 1'b1);

    start_cfg(3);
    send_rows(3, 1'b0);
    read_pass(0);
    read_pass(0);

    start_cfg(5);
    send_rows(5, 1'b0);
    read_pass(1);

    // abort a read pass at row 3 with a new config
    start_cfg(5);
    send_rows(5, 1'b0);
    rd_start_i = 1'b1;
    cycle();
    rd_start_i = 1'b0;
    base = iss_q.size(); guard = 0;
    while (iss_q.size() - base < 3 && guard < 100) begin cycle(); guard++; end
    cfg_start_i = 1'b1; cfg_rows_i = 7'd2;
    cycle();
    cfg_start_i = 1'b0;
    layer_n = 2;
    chk("abort_rdptr", 128'(iss_q[$]), 128'(3));
    chk("abort_s_ready", 128'(s_ready_o), 128'(1));
    chk("abort_loaded", 128'(loaded_o), 128'(0));
    chk("abort_inflight", 128'(w_valid_o), 128'(1));
    send_rows(2, 1'b0);
    read_pass(0);

    // config start and read start together: config wins
    base = iss_q.size();
    cfg_start_i = 1'b1; cfg_rows_i = 7'd3; rd_start_i = 1'b1;
    cycle();
    cfg_start_i = 1'b0; rd_start_i = 1'b0;
    layer_n = 3;
    chk("both_s_ready", 128'(s_ready_o), 128'(1));
    cycle();
    chk("both_no_read", 128'(iss_q.size() - base), 128'(0));
    send_rows(3, 1'b0);
    read_pass(2);

    // randomized layers
    for (int t = 0; t < 6; t++) begin
      start_cfg($urandom_range(1, 20));
      send_rows(layer_n, 1'b0);
      read_pass(2);
      if ($urandom_range(0, 1) == 1) read_pass(0);
    end

    // largest legal layer
    start_cfg(DEPTH - SK);
    send_rows(layer_n, 1'b0);
    read_pass(0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1);
  end
endmodule
